fetch: RTL and testbench

FETCH -- requirements
Module: fetch

---
 rtl/fetch.sv | 115 +++++++++++
 tb/tb_fetch.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch.sv
// Instruction fetch: one outstanding imem request, one instruction register presented to decode.
// Latency: request, then response, then output register; 2 cycles per instruction with zero-latency memory.
// Backpressure: stall holds the output register and drops imem_rsp_ready; the memory holds its response.
module fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter int          EX_WIDTH  = 1
) (
    input  logic                clk,
    input  logic                reset,
    output logic                imem_req_valid,
    input  logic                imem_req_ready,
    output logic [31:0]         imem_addr,
    input  logic                imem_rsp_valid,
    output logic                imem_rsp_ready,
    input  logic [31:0]         imem_rsp_data,
    input  logic                imem_rsp_err,
    input  logic                redirect_valid,
    input  logic [31:0]         redirect_pc,
    input  logic                stall,
    input  logic                flush,
    output logic [31:0]         PC_out,
    output logic [31:0]         instr_out,
    output logic [EX_WIDTH:0]   excep_out,
    output logic                pipeline_out_valid
);
    localparam logic [EX_WIDTH:0] EX_NONE               = '0;
    localparam logic [EX_WIDTH:0] EX_INSTR_MISALIGNED   = (EX_WIDTH + 1)'(1);
    localparam logic [EX_WIDTH:0] EX_INSTR_ACCESS_FAULT = (EX_WIDTH + 1)'(2);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic        kill;

    logic slot_free;
    logic req_fire;
    logic rsp_fire;
    logic pc_misaligned;

    // A misaligned pc can only come from a redirect; it is reported instead of fetched.
    assign pc_misaligned  = pc[1:0] != 2'b00;
    assign imem_req_valid = (state == S_REQ) && !reset && !pc_misaligned;
    assign imem_addr      = pc;
    assign slot_free      = !pipeline_out_valid || !stall;
    assign imem_rsp_ready = slot_free;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign rsp_fire       = imem_rsp_valid && imem_rsp_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= S_REQ;
            pc                 <= RESET_PC;
            kill               <= 1'b0;
            pipeline_out_valid <= 1'b0;
            PC_out             <= 32'h0;
            instr_out          <= NOP_INSTR;
            excep_out          <= EX_NONE;
        end else begin
            // Consumed or flushed output empties the slot; an emit below refills it.
            if (flush || slot_free)
                pipeline_out_valid <= 1'b0;

            case (state)
                S_REQ: begin
                    if (req_fire) begin
                        state <= S_WAIT;
                        kill  <= redirect_valid;
                    end else if (pc_misaligned && slot_free && !flush && !redirect_valid) begin
                        PC_out             <= pc;
                        instr_out          <= NOP_INSTR;
                        excep_out          <= EX_INSTR_MISALIGNED;
                        pipeline_out_valid <= 1'b1;
                        state              <= S_HALT;
                    end
                end
                S_WAIT: begin
                    if (rsp_fire) begin
                        state <= S_REQ;
                        kill  <= 1'b0;
                        // Flush without redirect drops the word and refetches the same pc.
                        if (!kill && !flush && !redirect_valid) begin
                            PC_out             <= pc;
                            pipeline_out_valid <= 1'b1;
                            if (imem_rsp_err) begin
                                instr_out <= NOP_INSTR;
                                excep_out <= EX_INSTR_ACCESS_FAULT;
                                state     <= S_HALT;
                            end else begin
                                instr_out <= imem_rsp_data;
                                excep_out <= EX_NONE;
                                pc        <= pc + 32'd4;
                            end
                        end
                    end else if (redirect_valid) begin
                        kill <= 1'b1;
                    end
                end
                S_HALT: begin
                    if (redirect_valid)
                        state <= S_REQ;
                end
                default: state <= S_REQ;
            endcase

            if (redirect_valid)
                pc <= redirect_pc;
        end
    end
endmodule

// File: tb/tb_fetch.sv
// Bench for fetch: directed cycle table, randomized run against a fetch-stream model, reset and wrap checks.
module tb_fetch;
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam int          EXN   = 0;
    localparam int          EXMIS = 1;
    localparam int          EXAF  = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid, imem_req_ready, imem_rsp_valid, imem_rsp_ready, imem_rsp_err;
    logic [31:0] imem_addr, imem_rsp_data, redirect_pc, PC_out, instr_out;
    logic        redirect_valid, stall, flush, pipeline_out_valid;
    logic [1:0]  excep_out;

    logic        w_qv, w_rr, w_rv, w_pov;
    logic [31:0] w_addr, w_pc, w_instr;
    logic [1:0]  w_ex;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fetch u_dut (
        .clk(clk), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_ready(imem_rsp_ready),
        .imem_rsp_data(imem_rsp_data), .imem_rsp_err(imem_rsp_err),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .stall(stall), .flush(flush),
        .PC_out(PC_out), .instr_out(instr_out), .excep_out(excep_out),
        .pipeline_out_valid(pipeline_out_valid)
    );

    fetch #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .reset(reset),
        .imem_req_valid(w_qv), .imem_req_ready(1'b1), .imem_addr(w_addr),
        .imem_rsp_valid(w_rv), .imem_rsp_ready(w_rr),
        .imem_rsp_data(32'h0000_0093), .imem_rsp_err(1'b0),
        .redirect_valid(1'b0), .redirect_pc(32'h0),
        .stall(1'b0), .flush(1'b0),
        .PC_out(w_pc), .instr_out(w_instr), .excep_out(w_ex),
        .pipeline_out_valid(w_pov)
    );

    typedef struct {
        logic st, fl, rdv; logic [31:0] rdpc;
        logic rv; logic [31:0] rd; logic re;
        logic qv; logic [31:0] qa; logic rr, ov;
        logic [31:0] opc, oin; logic [1:0] oex;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        int          lat;
    } mreq_t;

    function automatic vec_t mk(input int st, input int fl, input int rdv, input int rdpc,
                                input int rv, input int rd, input int re,
                                input int qv, input int qa, input int rr, input int ov,
                                input int opc, input int oin, input int oex);
        vec_t v;
        v.st = (st != 0); v.fl = (fl != 0); v.rdv = (rdv != 0); v.rdpc = 32'(rdpc);
        v.rv = (rv != 0); v.rd = 32'(rd); v.re = (re != 0);
        v.qv = (qv != 0); v.qa = 32'(qa); v.rr = (rr != 0); v.ov = (ov != 0);
        v.opc = 32'(opc); v.oin = 32'(oin); v.oex = 2'(oex);
        return v;
    endfunction

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    function automatic logic merr(input logic [31:0] a);
        return a[7:2] == 6'h2A;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        stall = 0; flush = 0; redirect_valid = 0; redirect_pc = 32'h0;
        imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = 32'h0; imem_rsp_err = 0;
        w_rv = 0;
    endtask

    localparam int NV = 25;
    vec_t  vt[NV];
    mreq_t mq[$];
    logic [31:0] exp_pc;
    logic        halted;
    int          ncons;

    initial begin
        // st fl rdv rdpc | rv rd re | qv qa rr ov opc oin oex
        vt[0]  = mk(0,0,0,0,      0,0,0,            1,32'h0,1,0,32'h0,NOP,EXN);
        vt[1]  = mk(0,0,0,0,      1,32'h00500093,0, 0,32'h0,1,0,32'h0,NOP,EXN);
        vt[2]  = mk(1,0,0,0,      0,0,0,            1,32'h4,0,1,32'h0,32'h00500093,EXN);
        vt[3]  = mk(1,0,0,0,      1,32'h00100113,0, 0,32'h4,0,1,32'h0,32'h00500093,EXN);
        vt[4]  = mk(1,0,0,0,      1,32'h00100113,0, 0,32'h4,0,1,32'h0,32'h00500093,EXN);
        vt[5]  = mk(0,0,0,0,      1,32'h00100113,0, 0,32'h4,1,1,32'h0,32'h00500093,EXN);
        vt[6]  = mk(0,0,0,0,      0,0,0,            1,32'h8,1,1,32'h4,32'h00100113,EXN);
        vt[7]  = mk(0,1,1,32'h100,0,0,0,            0,32'h8,1,0,32'h4,32'h00100113,EXN);
        vt[8]  = mk(0,0,0,0,      1,32'h00200193,0, 0,32'h100,1,0,32'h4,32'h00100113,EXN);
        vt[9]  = mk(0,0,0,0,      0,0,0,            1,32'h100,1,0,32'h4,32'h00100113,EXN);
        vt[10] = mk(0,0,0,0,      1,32'h00300213,0, 0,32'h100,1,0,32'h4,32'h00100113,EXN);
        vt[11] = mk(0,0,0,0,      0,0,0,            1,32'h104,1,1,32'h100,32'h00300213,EXN);
        vt[12] = mk(0,1,1,32'h10, 1,32'h00400293,0, 0,32'h104,1,0,32'h100,32'h00300213,EXN);
        vt[13] = mk(0,0,0,0,      0,0,0,            1,32'h10,1,0,32'h100,32'h00300213,EXN);
        vt[14] = mk(0,0,0,0,      1,32'hDEADBEEF,1, 0,32'h10,1,0,32'h100,32'h00300213,EXN);
        vt[15] = mk(0,0,0,0,      0,0,0,            0,32'h10,1,1,32'h10,NOP,EXAF);
        vt[16] = mk(0,0,0,0,      0,0,0,            0,32'h10,1,0,32'h10,NOP,EXAF);
        vt[17] = mk(0,0,1,32'h20, 0,0,0,            0,32'h10,1,0,32'h10,NOP,EXAF);
        vt[18] = mk(0,0,0,0,      0,0,0,            1,32'h20,1,0,32'h10,NOP,EXAF);
        vt[19] = mk(0,0,0,0,      1,32'h00500313,0, 0,32'h20,1,0,32'h10,NOP,EXAF);
        vt[20] = mk(0,1,1,32'h102,0,0,0,            1,32'h24,1,1,32'h20,32'h00500313,EXN);
        vt[21] = mk(0,0,0,0,      1,32'h00600393,0, 0,32'h102,1,0,32'h20,32'h00500313,EXN);
        vt[22] = mk(0,0,0,0,      0,0,0,            0,32'h102,1,0,32'h20,32'h00500313,EXN);
        vt[23] = mk(0,0,0,0,      0,0,0,            0,32'h102,1,1,32'h102,NOP,EXMIS);
        vt[24] = mk(0,0,0,0,      0,0,0,            0,32'h102,1,0,32'h102,NOP,EXMIS);

        idle_inputs();
        reset = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
        chk("rst_out_valid", 32'(pipeline_out_valid), 32'h0);
        chk("rst_pc_out", PC_out, 32'h0);
        chk("rst_instr", instr_out, NOP);
        chk("rst_excep", 32'(excep_out), 32'(EXN));
        @(posedge clk); #1;
        reset = 0;

        for (int i = 0; i < NV; i++) begin
            stall = vt[i].st; flush = vt[i].fl;
            redirect_valid = vt[i].rdv; redirect_pc = vt[i].rdpc;
            imem_req_ready = 1'b1;
            imem_rsp_valid = vt[i].rv; imem_rsp_data = vt[i].rd; imem_rsp_err = vt[i].re;
            @(negedge clk);
            total++;
            if (imem_req_valid !== vt[i].qv || imem_addr !== vt[i].qa || imem_rsp_ready !== vt[i].rr ||
                pipeline_out_valid !== vt[i].ov || PC_out !== vt[i].opc || instr_out !== vt[i].oin ||
                excep_out !== vt[i].oex) begin
                bad++;
                $display("FAIL vec%0d: got qv=%b addr=%h rr=%b ov=%b pc=%h ins=%h ex=%0d want qv=%b addr=%h rr=%b ov=%b pc=%h ins=%h ex=%0d",
                         i, imem_req_valid, imem_addr, imem_rsp_ready, pipeline_out_valid, PC_out, instr_out, excep_out,
                         vt[i].qv, vt[i].qa, vt[i].rr, vt[i].ov, vt[i].opc, vt[i].oin, vt[i].oex);
            end
            @(posedge clk); #1;
        end

        // Randomized run: decode consumes when valid && !stall && !flush; redirects always come with flush.
        idle_inputs();
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        exp_pc = 32'h0; halted = 0; ncons = 0;
        for (int c = 0; c < 3000; c++) begin
            stall          = ($urandom_range(0, 3) == 0);
            imem_req_ready = ($urandom_range(0, 2) != 0);
            redirect_valid = ($urandom_range(0, halted ? 3 : 40) == 0);
            flush          = redirect_valid;
            redirect_pc    = 32'($urandom_range(0, 1023)) << 2;
            if (mq.size() > 0 && mq[0].lat == 0) begin
                imem_rsp_valid = 1;
                imem_rsp_data  = mdata(mq[0].addr);
                imem_rsp_err   = merr(mq[0].addr);
            end else begin
                imem_rsp_valid = 0;
                imem_rsp_data  = $urandom;
                imem_rsp_err   = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            if (imem_req_valid)
                chk("one_outstanding", 32'(mq.size()), 32'h0);
            if (pipeline_out_valid && !stall && !flush) begin
                if (halted) begin
                    total++; bad++;
                    $display("FAIL out_while_halted: got pc %h want no output", PC_out);
                end else begin
                    chk("rnd_pc", PC_out, exp_pc);
                    if (merr(exp_pc)) begin
                        chk("rnd_fault_ex", 32'(excep_out), 32'(EXAF));
                        chk("rnd_fault_instr", instr_out, NOP);
                        halted = 1;
                    end else begin
                        chk("rnd_instr", instr_out, mdata(exp_pc));
                        chk("rnd_ex", 32'(excep_out), 32'(EXN));
                        exp_pc = exp_pc + 32'd4;
                    end
                    ncons++;
                end
            end
            if (imem_rsp_valid && imem_rsp_ready)
                void'(mq.pop_front());
            foreach (mq[k])
                if (mq[k].lat > 0) mq[k].lat--;
            if (imem_req_valid && imem_req_ready)
                mq.push_back('{imem_addr, int'($urandom_range(0, 3))});
            if (redirect_valid) begin
                exp_pc = redirect_pc;
                halted = 0;
            end
            @(posedge clk); #1;
        end
        total++;
        if (ncons < 100) begin
            bad++;
            $display("FAIL rnd_progress: got %0d instructions want at least 100", ncons);
        end

        // Reset mid-operation; the memory drops anything outstanding with it.
        idle_inputs();
        mq.delete();
        reset = 1;
        @(negedge clk);
        chk("midrst_req_valid", 32'(imem_req_valid), 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("midrst_out_valid", 32'(pipeline_out_valid), 32'h0);
        chk("midrst_pc_out", PC_out, 32'h0);
        chk("midrst_instr", instr_out, NOP);
        chk("midrst_excep", 32'(excep_out), 32'(EXN));
        @(posedge clk); #1;
        reset = 0;
        @(negedge clk);
        chk("post_rst_req_valid", 32'(imem_req_valid), 32'h1);
        chk("post_rst_addr", imem_addr, 32'h0);
        chk("wrap_first_addr", w_addr, 32'hFFFF_FFFC);
        chk("wrap_first_valid", 32'(w_qv), 32'h1);
        @(posedge clk); #1;
        w_rv = 1;
        @(negedge clk);
        chk("wrap_rsp_ready", 32'(w_rr), 32'h1);
        @(posedge clk); #1;
        w_rv = 0;
        @(negedge clk);
        chk("wrap_second_valid", 32'(w_qv), 32'h1);
        chk("wrap_second_addr", w_addr, 32'h0);
        chk("wrap_out_pc", w_pc, 32'hFFFF_FFFC);
        chk("wrap_out_instr", w_instr, 32'h0000_0093);
        chk("wrap_out_valid", 32'(w_pov), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
